// File: rtl/mc_cpu_pkg.sv
// ============================================================================
// mc_cpu_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the multi-cycle CPU slice. It holds the next-PC
// select codes driven by the control unit, the instruction field bit
// positions, the fetch FSM state type and the opcode constants that the
// control unit and the fetch unit agree on.
// ============================================================================
package mc_cpu_pkg;

    // Next-PC select codes carried on pc_src
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_REG    = 2'b10;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

    // Instruction field positions (MSB of each field, used with -: slices)
    localparam int OPC_MSB    = 31;
    localparam int RS_MSB     = 25;
    localparam int RT_MSB     = 20;
    localparam int RD_MSB     = 15;
    localparam int SHAMT_MSB  = 10;
    localparam int IMM_MSB    = 15;
    localparam int JTARG_MSB  = 25;
    localparam int REG_W      = 5;
    localparam int IMM_W      = 16;
    localparam int JTARG_W    = 26;

    // Fetch FSM states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Opcodes shared with the control unit
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mc_next_pc.sv
// ============================================================================
// mc_next_pc
// ----------------------------------------------------------------------------
// Combinational next-PC generator. All arithmetic wraps modulo 2^32.
//
// Ports:
//   i_pc        current PC
//   i_pcSrc     select: seq / branch / register / jump
//   i_immExt    extended immediate (word offset) for branches
//   i_rsData    register value for jr
//   i_jumpTarg  26-bit jump target field from the instruction register
//   o_pcPlus4   i_pc + 4
//   o_nextPc    selected next PC
// ============================================================================
module mc_next_pc
    import mc_cpu_pkg::*;
(
    input  logic [31:0]        i_pc,
    input  logic [1:0]         i_pcSrc,
    input  logic [31:0]        i_immExt,
    input  logic [31:0]        i_rsData,
    input  logic [JTARG_W-1:0] i_jumpTarg,
    output logic [31:0]        o_pcPlus4,
    output logic [31:0]        o_nextPc
);

    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;

    assign o_pcPlus4      = i_pc + 32'd4;
    assign w_branchTarget = o_pcPlus4 + {i_immExt[29:0], 2'b00};
    // Jumps stay inside the 256 MB region selected by the upper PC nibble
    assign w_jumpTarget   = {o_pcPlus4[31:28], i_jumpTarg, 2'b00};

    // Next-PC mux
    always_comb begin
        o_nextPc = o_pcPlus4;
        unique case (i_pcSrc)
            PC_SRC_SEQ:    o_nextPc = o_pcPlus4;
            PC_SRC_BRANCH: o_nextPc = w_branchTarget;
            PC_SRC_REG:    o_nextPc = i_rsData;
            PC_SRC_JUMP:   o_nextPc = w_jumpTarget;
            default:       o_nextPc = o_pcPlus4;
        endcase
    end

endmodule

// File: rtl/mc_fetch_unit.sv
// ============================================================================
// mc_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch unit for the multi-cycle CPU. Owns PC and IR, applies the
// control unit's pc_wre / ir_wre / pc_src strobes, runs a req/ack read to
// instruction memory and returns decoded instruction fields.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc_wre, ir_wre        PC update / fetch start strobes
//   pc_src, imm_ext,      next-PC select and its operands
//   rs_data
//   imem_req/addr/rdata/  instruction memory read handshake
//   imem_ack
//   pc, pc_plus4          current PC and PC + 4
//   ir, ir_valid          instruction register and its valid flag
//   fetch_busy            a fetch is outstanding
//   opcode, rs, rt, rd,   decoded fields of ir
//   shamt, imm16
//   fetch_overrun         one-cycle pulse when ir_wre arrives while busy
//   align_fault           sticky misaligned next-PC flag
//
// Configuration:
//   MC_FETCH_ALIGN_CHECK_EN  when defined, a misaligned next-PC is not loaded,
//                            align_fault is set (sticky) and further fetches
//                            are refused. When undefined, align_fault is 0.
// ============================================================================
module mc_fetch_unit
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] INIT_PC = 32'h0000_0000,
    parameter int          OPC_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_wre,
    input  logic             ir_wre,
    input  logic [1:0]       pc_src,
    input  logic [31:0]      imm_ext,
    input  logic [31:0]      rs_data,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      ir,
    output logic             ir_valid,
    output logic             fetch_busy,
    output logic [OPC_W-1:0] opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [15:0]      imm16,
    output logic             fetch_overrun,
    output logic             align_fault
);

    fetch_state_e r_state;
    fetch_state_e w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_irValid;
    logic [31:0] r_imemAddr;
    logic        r_overrun;

    logic [31:0] w_nextPc;
    logic [31:0] w_pcPlus4;
    logic        w_pcLoad;
    logic        w_fetchReq;
    logic        w_startFetch;
    logic        w_completeFetch;

    mc_next_pc u_nextPc (
        .i_pc       (r_pc),
        .i_pcSrc    (pc_src),
        .i_immExt   (imm_ext),
        .i_rsData   (rs_data),
        .i_jumpTarg (r_ir[JTARG_MSB -: JTARG_W]),
        .o_pcPlus4  (w_pcPlus4),
        .o_nextPc   (w_nextPc)
    );

`ifdef MC_FETCH_ALIGN_CHECK_EN
    logic r_alignFault;
    logic w_misaligned;

    assign w_misaligned = (w_nextPc[1:0] != 2'b00);
    assign w_pcLoad     = pc_wre && !w_misaligned;
    assign w_fetchReq   = ir_wre && !r_alignFault;
    assign align_fault  = r_alignFault;

    // Sticky fault: once a misaligned target is refused, the unit stays
    // halted for fetches until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alignFault <= 1'b0;
        end else if (pc_wre && w_misaligned) begin
            r_alignFault <= 1'b1;
        end
    end
`else
    assign w_pcLoad    = pc_wre;
    assign w_fetchReq  = ir_wre;
    assign align_fault = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; ack in IDLE and ir_wre in WAIT are both ignored
    always_comb begin
        w_stateNext     = r_state;
        w_startFetch    = 1'b0;
        w_completeFetch = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fetchReq) begin
                    w_startFetch = 1'b1;
                    w_stateNext  = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    w_completeFetch = 1'b1;
                    w_stateNext     = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // PC register; updates in any fetch state. The fetch address is
    // captured from the pre-update PC in the block below.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= INIT_PC;
        end else if (w_pcLoad) begin
            r_pc <= w_nextPc;
        end
    end

    // Fetch datapath: address latch, IR capture, valid flag, overrun pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imemAddr <= 32'h0000_0000;
            r_ir       <= 32'h0000_0000;
            r_irValid  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= (r_state == WAIT) && ir_wre;
            if (w_startFetch) begin
                r_imemAddr <= r_pc;
                r_irValid  <= 1'b0;
            end
            if (w_completeFetch) begin
                r_ir      <= imem_rdata;
                r_irValid <= 1'b1;
            end
        end
    end

    assign imem_req      = (r_state == WAIT);
    assign fetch_busy    = (r_state == WAIT);
    assign imem_addr     = r_imemAddr;
    assign pc            = r_pc;
    assign pc_plus4      = w_pcPlus4;
    assign ir            = r_ir;
    assign ir_valid      = r_irValid;
    assign fetch_overrun = r_overrun;

    assign opcode = r_ir[OPC_MSB -: OPC_W];
    assign rs     = r_ir[RS_MSB -: REG_W];
    assign rt     = r_ir[RT_MSB -: REG_W];
    assign rd     = r_ir[RD_MSB -: REG_W];
    assign shamt  = r_ir[SHAMT_MSB -: REG_W];
    assign imm16  = r_ir[IMM_MSB -: IMM_W];

endmodule
